// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: in-order FIFO-fed sequencer for the reg_file + alu datapath.
// Option macro ALU_ISSUE_R0_ZERO_EN: register 0 reads as zero and is never written.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_W-1:0]       cmd_src1,
  input  logic [ADDR_W-1:0]       cmd_src2,
  input  logic [ADDR_W-1:0]       cmd_dst,
  output logic [ADDR_W-1:0]       rf_rd_addr1,
  output logic [ADDR_W-1:0]       rf_rd_addr2,
  input  logic [DATA_W-1:0]       rf_rd_data1,
  input  logic [DATA_W-1:0]       rf_rd_data2,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [1:0]              alu_sel,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    rf_wr_en,
  output logic [ADDR_W-1:0]       rf_wr_addr,
  output logic [DATA_W-1:0]       rf_wr_data,
  output logic                    done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] rd_addr1_q;
  logic [ADDR_W-1:0] rd_addr2_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [1:0]        alu_sel_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q;

  cmd_t              head;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              wr_ok;

  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = rst_n && (cnt_q != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = ((state_q == S_IDLE) ||
                      (state_q == S_WB)) &&
                     (cnt_q != '0);

`ifdef ALU_ISSUE_R0_ZERO_EN
  assign opa   = (rd_addr1_q == '0) ? '0 : rf_rd_data1;
  assign opb   = (rd_addr2_q == '0) ? '0 : rf_rd_data2;
  assign wr_ok = (dst_q != '0);
`else
  assign opa   = rf_rd_data1;
  assign opb   = rf_rd_data2;
  assign wr_ok = 1'b1;
`endif

  // FIFO storage; contents need no reset, pointers guard validity
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {cmd_op, cmd_src1, cmd_src2, cmd_dst};
  end

  // FIFO pointers and occupancy; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sequencer: pop -> READ -> EXEC -> WB, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE, S_WB: begin
          if (pop) begin
            op_q       <= head.op;
            dst_q      <= head.dst;
            rd_addr1_q <= head.src1;
            rd_addr2_q <= head.src2;
            state_q    <= S_READ;
          end else begin
            state_q    <= S_IDLE;
          end
        end
        S_READ: begin
          alu_a_q   <= opa;
          alu_b_q   <= opb;
          alu_sel_q <= op_q;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          wr_data_q <= alu_result;
          wr_addr_q <= dst_q;
          wr_en_q   <= wr_ok;
          done_q    <= 1'b1;
          state_q   <= S_WB;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rf_rd_addr1 = rd_addr1_q;
  assign rf_rd_addr2 = rd_addr2_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign rf_wr_en    = wr_en_q;
  assign rf_wr_addr  = wr_addr_q;
  assign rf_wr_data  = wr_data_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE) || (cnt_q != '0);
  assign fifo_count  = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + random bench with reg_file/ALU environment
// and an in-order scoreboard applying commands to a model register array.
module tb_alu_issue_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src1;
  logic [AW-1:0] cmd_src2;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] rf_rd_addr1;
  logic [AW-1:0] rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1;
  logic [DW-1:0] rf_rd_data2;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_sel;
  logic [DW-1:0] alu_result;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          done;
  logic          busy;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1),
    .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .done(done), .busy(busy),
    .fifo_count(fifo_count)
  );

  function automatic logic [DW-1:0] alu_f(
    input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // environment: register file and ALU
  logic [DW-1:0] regs [32];
  assign rf_rd_data1 = regs[rf_rd_addr1];
  assign rf_rd_data2 = regs[rf_rd_addr2];
  assign alu_result  = alu_f(alu_sel, alu_a, alu_b);

  always @(posedge clk) begin
    if (rf_wr_en) regs[rf_wr_addr] <= rf_wr_data;
  end

  // reference model
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] d;
  } cmd_t;

  logic [DW-1:0] mreg [32];
  cmd_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (a == 0) return '0;
`endif
    return mreg[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready)
      exp_q.push_back({cmd_op, cmd_src1, cmd_src2, cmd_dst});
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_rule", cmd_ready, fifo_count != 3'd4);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_done observed=1 expected=0");
        end else begin
          cmd_t          c;
          logic [DW-1:0] res;
          logic          we;
          c   = exp_q.pop_front();
          res = alu_f(c.op, rd_model(c.s1), rd_model(c.s2));
          we  = 1'b1;
`ifdef ALU_ISSUE_R0_ZERO_EN
          we  = (c.d != 0);
`endif
          chk("wb_en", rf_wr_en, we);
          chk("wb_addr", rf_wr_addr, c.d);
          chk("wb_data", rf_wr_data, res);
          if (we) mreg[c.d] <= res;
        end
      end else begin
        chk("wr_en_outside_wb", rf_wr_en, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [1:0] op, input logic [AW-1:0] s1,
                      input logic [AW-1:0] s2, input logic [AW-1:0] d);
    bit acc = 0;
    int n   = 0;
    cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d;
    cmd_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("push_accepted", acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 30);
  endtask

  initial begin
    int k;
    int full_seen;
    bit acc;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
    for (int i = 0; i < 32; i++) begin
      regs[i] <= 32'(2 * i);
      mreg[i] <= 32'(2 * i);
    end
    repeat (2) @(negedge clk);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rd_addr1", rf_rd_addr1, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    @(posedge clk); #1;

    // 1: single command latency
    push(2'd0, 5'd3, 5'd5, 5'd7);
    wait_done(k);
    chk("t1_latency", k, 4);
    wait_idle();
    chk("t1_reg7", regs[7], 16);
    @(posedge clk); #1;

    // 2: back-to-back with RAW dependency
    push(2'd0, 5'd1, 5'd2, 5'd4);
    push(2'd1, 5'd4, 5'd1, 5'd9);
    wait_done(k);
    wait_done(k);
    chk("t2_spacing", k, 3);
    wait_idle();
    chk("t2_reg4", regs[4], 6);
    chk("t2_reg9", regs[9], 4);
    @(posedge clk); #1;

    // 4: reset during EXEC aborts the write
    push(2'd2, 5'd6, 5'd3, 5'd8);
    repeat (3) @(negedge clk);
    chk("t4_exec_sel", alu_sel, 2);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t4_count", fifo_count, 0);
    chk("t4_busy", busy, 0);
    chk("t4_wr_en", rf_wr_en, 0);
    repeat (2) @(negedge clk);
    chk("t4_done", done, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_reg8", regs[8], 16);
    chk("t4_busy_after", busy, 0);
    @(posedge clk); #1;

    // 5: destination register 0
    push(2'd3, 5'd0, 5'd5, 5'd0);
    wait_idle();
`ifdef ALU_ISSUE_R0_ZERO_EN
    chk("t5_reg0", regs[0], 0);
`else
    chk("t5_reg0", regs[0], 10);
`endif
    @(posedge clk); #1;

    // 6: push on the WB edge that pops the last entry
    push(2'd0, 5'd2, 5'd3, 5'd10);
    push(2'd1, 5'd6, 5'd7, 5'd11);
    wait_done(k);
    chk("t6_count_wb", fifo_count, 1);
    #1;
    cmd_op = 2'd2; cmd_src1 = 5'd12; cmd_src2 = 5'd13; cmd_dst = 5'd14;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_count_after", fifo_count, 1);
    chk("t6_read_addr1", rf_rd_addr1, 6);
    chk("t6_read_addr2", rf_rd_addr2, 7);
    wait_done(k);
    chk("t6_spacing", k, 2);
    wait_idle();
    @(posedge clk); #1;

    // 3: hold valid while busy until the FIFO fills
    full_seen = 0;
    cmd_op = 2'($urandom); cmd_src1 = 5'($urandom);
    cmd_src2 = 5'($urandom); cmd_dst = 5'($urandom);
    cmd_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      acc = cmd_ready;
      if (fifo_count == 3'd4) begin
        full_seen++;
        chk("t3_full_ready", cmd_ready, 0);
      end
      @(posedge clk); #1;
      if (acc) begin
        cmd_op = 2'($urandom); cmd_src1 = 5'($urandom);
        cmd_src2 = 5'($urandom); cmd_dst = 5'($urandom);
      end
    end
    cmd_valid = 1'b0;
    chk("t3_full_seen", full_seen != 0, 1);
    wait_idle();
    chk("t3_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // random traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      push(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk("final_reg", regs[i], mreg[i]);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
